// File: rtl/load_store_unit.sv
// Memory-access stage: posts stores into an in-order store buffer that drains through write
// port 1, and serves loads from read port 1 with store-to-load forwarding from that buffer.
module load_store_unit #(
  parameter int unsigned SB_DEPTH = 4,
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned TAG_W    = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_write,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [DATA_W-1:0]           req_wdata,
  input  logic [TAG_W-1:0]            req_tag,
  output logic                        resp_valid,
  output logic [DATA_W-1:0]           resp_data,
  output logic [TAG_W-1:0]            resp_tag,
  output logic [ADDR_W-1:0]           mem_rd_addr,
  input  logic [DATA_W-1:0]           mem_rd_data,
  input  logic                        mem_wr_grant,
  output logic [ADDR_W-1:0]           mem_wr_addr,
  output logic [DATA_W-1:0]           mem_wr_data,
  output logic                        mem_wr_enable,
  output logic [$clog2(SB_DEPTH):0]   sb_count,
  output logic                        sb_empty
);

  localparam int unsigned PtrW = $clog2(SB_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [ADDR_W-1:0] addr_q [SB_DEPTH];
  logic [DATA_W-1:0] data_q [SB_DEPTH];
  logic [SB_DEPTH-1:0] valid_q, valid_d;

  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic              resp_valid_q;
  logic [DATA_W-1:0] resp_data_q, resp_data_d;
  logic [TAG_W-1:0]  resp_tag_q, resp_tag_d;

  logic accept;
  logic push;
  logic load;
  logic drain;

  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [PtrW-1:0]   fwd_idx;
  logic [DATA_W-1:0] load_data;

  // A separate occupancy count keeps full and empty exact when head == tail.
  assign sb_count      = count_q;
  assign sb_empty      = (count_q == '0);
  assign req_ready     = (count_q < CntW'(SB_DEPTH));
  assign accept        = req_valid && req_ready;
  assign push          = accept && req_write;
  assign load          = accept && !req_write;
  assign drain         = !sb_empty && mem_wr_grant;

  assign mem_rd_addr   = req_addr;
  assign mem_wr_enable = drain;
  assign mem_wr_addr   = addr_q[head_q];
  assign mem_wr_data   = data_q[head_q];

  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign resp_tag      = resp_tag_q;

  // Walk oldest to youngest so the last hit (closest to tail) wins. Valid entries are
  // contiguous from head, and a draining entry stays valid until the edge.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < int'(SB_DEPTH); i++) begin
      fwd_idx = head_q + PtrW'(i);
      if (valid_q[fwd_idx] && (addr_q[fwd_idx] == req_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  assign load_data = fwd_hit ? fwd_data : mem_rd_data;

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    valid_d     = valid_q;
    resp_data_d = resp_data_q;
    resp_tag_d  = resp_tag_q;

    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    // Push never targets the head slot while it is draining: that would need a full buffer.
    if (drain) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end

    unique case ({push, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (load) begin
      resp_data_d = load_data;
      resp_tag_d  = req_tag;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      valid_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      resp_valid_q <= load;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
    end
  end

  // Payload storage needs no reset; valid bits gate every use.
  always_ff @(posedge clock) begin
    if (push) begin
      addr_q[tail_q] <= req_addr;
      data_q[tail_q] <= req_wdata;
    end
  end

  a_count_bound: assert property (@(posedge clock) disable iff (!reset)
    count_q <= CntW'(SB_DEPTH));
  a_valid_matches_count: assert property (@(posedge clock) disable iff (!reset)
    $countones(valid_q) == int'(count_q));
  a_no_drain_when_empty: assert property (@(posedge clock) disable iff (!reset)
    mem_wr_enable |-> !sb_empty);

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly upstream of the data memory. It takes one load or store per cycle from execute and drives the memory's read port 1 and write port 1.
- Stores are posted into an in-order store buffer. The buffer drains to memory whenever the shared write port is granted.
- Loads read memory combinationally and take store-to-load forwarding from the buffer. Each load returns its result one cycle after acceptance.

Parameters:
- SB_DEPTH, 4, store-buffer entries; power of two, at least 2.
- ADDR_W, 9, word address width; covers the 512-word data memory.
- DATA_W, 16, data word width.
- TAG_W, 4, destination register tag carried with loads.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  execute presents a request.
- req_ready  out  1  unit can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data.
- req_tag  in  TAG_W  load destination tag.
- resp_valid  out  1  load result valid; single-cycle pulse, no backpressure.
- resp_data  out  DATA_W  load result.
- resp_tag  out  TAG_W  tag of the returned load.
- mem_rd_addr  out  ADDR_W  memory read port 1 address.
- mem_rd_data  in  DATA_W  memory read port 1 data; combinational from mem_rd_addr.
- mem_wr_grant  in  1  write port 1 is available this cycle.
- mem_wr_addr  out  ADDR_W  memory write port 1 address.
- mem_wr_data  out  DATA_W  memory write port 1 data.
- mem_wr_enable  out  1  memory write port 1 enable.
- sb_count  out  clog2(SB_DEPTH)+1  occupied store-buffer entries.
- sb_empty  out  1  sb_count == 0.

Behaviour:
- Reset (asserted low, asynchronous) clears:
  - head pointer, tail pointer and count to 0;
  - all entry valid bits to 0;
  - resp_valid, resp_data and resp_tag to 0.
- While reset is held: mem_wr_enable = 0, sb_empty = 1, sb_count = 0, req_ready = 1.
- Reset asserted mid-operation discards all buffered stores; none is written to memory.
- Accept: a request is accepted when req_valid && req_ready. req_ready = (sb_count < SB_DEPTH). req_ready is 0 when the buffer is full, even in a cycle where a drain also occurs.
- Store accept: the entry {addr, wdata} is written at the tail, tail increments modulo SB_DEPTH, and count increments.
- Drain:
  - mem_wr_enable = !sb_empty && mem_wr_grant; mem_wr_addr and mem_wr_data are the head entry.
  - When mem_wr_enable = 1, at the edge head increments modulo SB_DEPTH and count decrements.
  - mem_wr_addr and mem_wr_data always show the head entry, even when not enabled.
  - Drains occur in program order, at most one per cycle.
- Simultaneous push and drain: count is unchanged, both pointers advance.
- Pointers wrap using one extra bit or a separate count. Full and empty must both be exact at wrap.
- Load accept:
  - mem_rd_addr = req_addr combinationally; mem_rd_addr is driven with req_addr every cycle.
  - In the same cycle, every valid buffer entry is compared against req_addr.
  - If any entry matches, the youngest match (closest to tail) supplies the data; otherwise mem_rd_data is used.
  - The result and req_tag are registered. At the next edge resp_valid = 1, resp_data = result, resp_tag = tag.
  - Load-to-response latency is exactly 1 cycle.
- resp_valid deasserts the following cycle unless another load is accepted; back-to-back loads give back-to-back responses.
- An entry being drained in the same cycle as a load still forwards: it remains valid until the edge.
- A load accepted one cycle after a store to the same address returns the stored data, whether or not that store has drained.
- Loads never stall for buffer contents. A load is refused only when the buffer is full, because req_ready is shared by both request types.
- Stores to the same address are not merged; each occupies its own entry and drains separately.
- resp_data and resp_tag hold their last value while resp_valid = 0.

Test Plan:
- Reset release with no traffic -> req_ready = 1, sb_empty = 1, resp_valid = 0, mem_wr_enable = 0 on every cycle.
- mem_wr_grant = 1; store addr 0x005 data 0xBEEF -> the cycle after accept shows mem_wr_enable = 1, mem_wr_addr = 0x005, mem_wr_data = 0xBEEF; the next cycle shows sb_empty = 1.
- mem_wr_grant = 0; four stores to 0x010..0x013 -> sb_count = 4, req_ready = 0. Raise grant -> four drains in order 0x010..0x013; req_ready returns to 1 after the first drain.
- mem_wr_grant = 0; store 0x020 = 0x1111, store 0x020 = 0x2222, then load 0x020 tag 3 with memory holding 0x0000 -> next cycle resp_valid = 1, resp_data = 0x2222, resp_tag = 3.
- Load 0x1FF with mem_rd_data = 0xA5A5 and an empty buffer -> resp_data = 0xA5A5 exactly one cycle later. Back-to-back loads give resp_valid high for 2 consecutive cycles.
- Three stores buffered with grant = 0, then reset pulsed low mid-cycle -> outputs clear immediately, and no write reaches memory after reset is released with grant = 1.
